// File: rtl/traffic_light_pkg.sv
// Light request code shared by the phase sequencer and the light FSM that decodes it.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    CODE_RED     = 2'b00,
    CODE_RED_YEL = 2'b01,
    CODE_GREEN   = 2'b10,
    CODE_YELLOW  = 2'b11
  } light_code_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/tl_debounce.sv
// Two-flop synchroniser followed by a stability filter: dout follows the synced
// input only after it has differed from dout for DEBOUNCE consecutive cycles.
module tl_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rstb,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync1_q, sync2_q;
  logic          dout_q, dout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A return to the current output level clears the count, so any glitch restarts it.
  always_comb begin
    cnt_d  = '0;
    dout_d = dout_q;
    if (sync2_q != dout_q) begin
      if (cnt_q == CNT_LAST) begin
        dout_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Timed RED -> RED_YEL -> GREEN -> YELLOW sequencer with car-sensor debounce and
// pedestrian walk service; produces the light request code for the light FSM.
module traffic_phase_sequencer
  import traffic_light_pkg::*;
#(
  parameter int TICK_DIV  = 10,
  parameter int RED_MIN   = 3,
  parameter int RY_TICKS  = 1,
  parameter int GREEN_MIN = 2,
  parameter int GREEN_MAX = 5,
  parameter int YEL_TICKS = 2,
  parameter int DEBOUNCE  = 3
) (
  input  logic clk,
  input  logic rstb,
  input  logic car_sense,
  input  logic ped_button,
  output logic code_a,
  output logic code_b,
  output logic ped_walk,
  output logic ped_ack,
  output logic phase_tick
);

  localparam int PW  = $clog2(TICK_DIV);
  localparam int DW  = $clog2(max4(RED_MIN, RY_TICKS, GREEN_MAX, YEL_TICKS) + 1);
  localparam int DW1 = DW + 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0]  DWELL_SAT  = '1;
  localparam logic [DW1-1:0] RED_MIN_W  = DW1'(RED_MIN);
  localparam logic [DW1-1:0] RY_W       = DW1'(RY_TICKS);
  localparam logic [DW1-1:0] GMIN_W     = DW1'(GREEN_MIN);
  localparam logic [DW1-1:0] GMAX_W     = DW1'(GREEN_MAX);
  localparam logic [DW1-1:0] YEL_W      = DW1'(YEL_TICKS);

  logic           car_q;
  logic [PW-1:0]  presc_q, presc_d;
  light_code_e    state_q, state_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic [DW1-1:0] dwell_inc;
  logic [2:0]     ped_sync_q, ped_sync_d;
  logic           pend_q, pend_d;
  logic           walk_q, walk_d;
  logic           ack_q, ack_d;
  logic           tick_q, tick_d;
  logic           tick, ped_rise, serve, restart, leave;

  tl_debounce #(.DEBOUNCE(DEBOUNCE)) u_car_db (
    .clk  (clk),
    .rstb (rstb),
    .din  (car_sense),
    .dout (car_q)
  );

  always_comb begin
    tick       = (presc_q == PRESC_LAST);
    presc_d    = tick ? '0 : presc_q + PW'(1);
    tick_d     = (presc_d == PRESC_LAST);
    ped_sync_d = {ped_sync_q[1:0], ped_button};
    ped_rise   = ped_sync_q[1] & ~ped_sync_q[2];
    // One bit wider than dwell so a saturated count still compares correctly.
    dwell_inc  = {1'b0, dwell_q} + DW1'(1);
    state_d    = state_q;
    serve      = 1'b0;
    restart    = 1'b0;
    if (tick) begin
      case (state_q)
        CODE_RED: begin
          if (!walk_q && pend_q) begin
            serve   = 1'b1;
            restart = 1'b1;
          end else if (dwell_inc >= RED_MIN_W && car_q) begin
            state_d = CODE_RED_YEL;
          end
        end
        CODE_RED_YEL: begin
          if (dwell_inc >= RY_W) state_d = CODE_GREEN;
        end
        CODE_GREEN: begin
          if (dwell_inc >= GMAX_W || (dwell_inc >= GMIN_W && (pend_q || !car_q)))
            state_d = CODE_YELLOW;
        end
        CODE_YELLOW: begin
          if (dwell_inc >= YEL_W) begin
            state_d = CODE_RED;
            serve   = pend_q;
          end
        end
      endcase
    end
    leave = (state_d != state_q);
    if (leave || restart) begin
      dwell_d = '0;
    end else if (tick && dwell_q != DWELL_SAT) begin
      dwell_d = dwell_inc[DW-1:0];
    end else begin
      dwell_d = dwell_q;
    end
    // A new press in the serving cycle survives the clear and waits for the next RED.
    walk_d = leave ? serve : (walk_q | serve);
    ack_d  = serve;
    pend_d = (pend_q & ~serve) | ped_rise;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      presc_q    <= '0;
      state_q    <= CODE_RED;
      dwell_q    <= '0;
      ped_sync_q <= '0;
      pend_q     <= 1'b0;
      walk_q     <= 1'b0;
      ack_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      ped_sync_q <= ped_sync_d;
      pend_q     <= pend_d;
      walk_q     <= walk_d;
      ack_q      <= ack_d;
      tick_q     <= tick_d;
    end
  end

  assign {code_a, code_b} = state_q;
  assign ped_walk         = walk_q;
  assign ped_ack          = ack_q;
  assign phase_tick       = tick_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed phase-timing and pedestrian scenarios plus a randomized run checked
// against a rule-level reference model of the sequencer.
module tb_traffic_phase_sequencer;

  localparam int TD = 4, RMIN = 3, RY = 1, GMIN = 2, GMAX = 5, YEL = 2, DB = 3;
  localparam int DSAT = 7;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic car_sense = 1'b0, ped_button = 1'b0;
  logic code_a, code_b, ped_walk, ped_ack, phase_tick;

  int n_tests = 0;
  int n_fail  = 0;

  traffic_phase_sequencer #(
    .TICK_DIV(TD), .RED_MIN(RMIN), .RY_TICKS(RY), .GREEN_MIN(GMIN),
    .GREEN_MAX(GMAX), .YEL_TICKS(YEL), .DEBOUNCE(DB)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .car_sense  (car_sense),
    .ped_button (ped_button),
    .code_a     (code_a),
    .code_b     (code_b),
    .ped_walk   (ped_walk),
    .ped_ack    (ped_ack),
    .phase_tick (phase_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reset held for two cycles, released at a falling edge (that sample is cycle 0).
  task automatic do_reset();
    rstb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic run_len(input logic [1:0] c, input int limit, output int len);
    len = 0;
    while ({code_a, code_b} == c && len < limit) begin
      len++;
      @(negedge clk);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_cyc, m_dwell;
  logic [1:0] m_code;
  logic       m_walk, m_ack, m_pend, m_carq, m_tick;
  bit         car_h[$];
  bit         btn_h[$];

  task automatic model_reset();
    m_cyc = 0; m_dwell = 0; m_code = 2'd0;
    m_walk = 0; m_ack = 0; m_pend = 0; m_carq = 0; m_tick = 0;
    car_h = {}; btn_h = {};
    for (int i = 0; i < 8; i++) begin
      car_h.push_back(1'b0);
      btn_h.push_back(1'b0);
    end
  endtask

  // Called once per rising edge with the inputs sampled there; history index j
  // holds the raw input from j edges ago, so index 2 is the synchronised level.
  task automatic model_step(input bit car_in, input bit btn_in);
    bit tick, serve, restart, rise, stable;
    int r;
    logic [1:0] nxt;
    car_h.push_front(car_in); void'(car_h.pop_back());
    btn_h.push_front(btn_in); void'(btn_h.pop_back());
    tick = (m_cyc % TD) == TD - 1;
    rise = btn_h[2] && !btn_h[3];
    serve = 0; restart = 0; nxt = m_code; r = m_dwell + 1;
    if (tick) begin
      if (m_code == 2'd0) begin
        if (!m_walk && m_pend) begin serve = 1; restart = 1; end
        else if (r >= RMIN && m_carq) nxt = 2'd1;
      end else if (m_code == 2'd1) begin
        if (r >= RY) nxt = 2'd2;
      end else if (m_code == 2'd2) begin
        if (r >= GMAX || (r >= GMIN && (m_pend || !m_carq))) nxt = 2'd3;
      end else begin
        if (r >= YEL) begin nxt = 2'd0; serve = m_pend; end
      end
    end
    if (nxt != m_code) $display("[TB] cycle %0d phase %0d -> %0d walk=%0b", m_cyc, m_code, nxt, serve);
    if (nxt != m_code || restart) m_dwell = 0;
    else if (tick) m_dwell = (m_dwell + 1 > DSAT) ? DSAT : m_dwell + 1;
    m_walk = (nxt == 2'd0) && (serve || (m_walk && nxt == m_code));
    m_code = nxt;
    m_ack  = serve;
    m_pend = (m_pend && !serve) || rise;
    stable = 1;
    for (int j = 3; j <= DB + 1; j++) if (car_h[j] != car_h[2]) stable = 0;
    if (stable && car_h[2] != m_carq) m_carq = car_h[2];
    m_cyc++;
    m_tick = (m_cyc % TD) == TD - 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] mask;
    car_sense = 0; ped_button = 0; rstb = 0;
    @(negedge clk); @(negedge clk);
    n_tests++;
    if ({code_a, code_b, ped_walk, ped_ack, phase_tick} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected 00000", {code_a, code_b, ped_walk, ped_ack, phase_tick});
    end
    rstb = 1;
    mask = '0;
    for (int c = 0; c < 8; c++) begin
      mask[c] = phase_tick;
      @(negedge clk);
    end
    n_tests++;
    if (mask !== 8'h88) begin
      n_fail++;
      $display("FAIL tick_pattern: got %b, expected 10001000", mask);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_car_cycle();
    int l;
    car_sense = 1; ped_button = 0; do_reset();
    run_len(2'd0, 40, l); n_tests++;
    if (l != 12) begin n_fail++; $display("FAIL car_red_len: got %0d, expected 12", l); end
    run_len(2'd1, 40, l); n_tests++;
    if (l != 4) begin n_fail++; $display("FAIL car_ry_len: got %0d, expected 4", l); end
    run_len(2'd2, 40, l); n_tests++;
    if (l != 20) begin n_fail++; $display("FAIL car_green_len: got %0d, expected 20", l); end
    run_len(2'd3, 40, l); n_tests++;
    if (l != 8) begin n_fail++; $display("FAIL car_yel_len: got %0d, expected 8", l); end
    n_tests++;
    if ({code_a, code_b} !== 2'd0) begin
      n_fail++; $display("FAIL car_back_red: got %0d, expected 0", {code_a, code_b});
    end
    $display("[TB] test_car_cycle done");
  endtask

  task automatic test_short_pulse();
    int nonred, ticks;
    car_sense = 0; ped_button = 0; do_reset();
    nonred = 0; ticks = 0;
    for (int c = 0; c < 200; c++) begin
      if ({code_a, code_b} != 2'd0) nonred++;
      if (phase_tick) ticks++;
      if (c == 20) car_sense = 1;
      if (c == 22) car_sense = 0;
      @(negedge clk);
    end
    n_tests++;
    if (nonred != 0) begin n_fail++; $display("FAIL glitch_nonred: got %0d, expected 0", nonred); end
    n_tests++;
    if (ticks != 50) begin n_fail++; $display("FAIL tick_count: got %0d, expected 50", ticks); end
    $display("[TB] test_short_pulse done");
  endtask

  task automatic test_ped_green();
    int l;
    car_sense = 1; ped_button = 0; do_reset();
    run_len(2'd0, 40, l);
    run_len(2'd1, 40, l);
    ped_button = 1;
    run_len(2'd2, 40, l); n_tests++;
    if (l != 8) begin n_fail++; $display("FAIL ped_green_len: got %0d, expected 8", l); end
    ped_button = 0;
    run_len(2'd3, 40, l); n_tests++;
    if (l != 8) begin n_fail++; $display("FAIL ped_yel_len: got %0d, expected 8", l); end
    n_tests++;
    if ({code_a, code_b, ped_walk, ped_ack} !== 4'b0011) begin
      n_fail++; $display("FAIL ped_red_entry: got %b, expected 0011", {code_a, code_b, ped_walk, ped_ack});
    end
    @(negedge clk); n_tests++;
    if ({code_a, code_b, ped_walk, ped_ack} !== 4'b0010) begin
      n_fail++; $display("FAIL ped_ack_single: got %b, expected 0010", {code_a, code_b, ped_walk, ped_ack});
    end
    run_len(2'd0, 40, l); n_tests++;
    if (l != 11) begin n_fail++; $display("FAIL walk_red_len: got %0d, expected 11", l); end
    n_tests++;
    if ({code_a, code_b, ped_walk} !== 3'b010) begin
      n_fail++; $display("FAIL walk_drop: got %b, expected 010", {code_a, code_b, ped_walk});
    end
    $display("[TB] test_ped_green done");
  endtask

  task automatic test_ped_red();
    int first_ack, acks, walk_lost, walk_early, nonred;
    car_sense = 0; ped_button = 0; do_reset();
    first_ack = -1; acks = 0; walk_lost = 0; walk_early = 0; nonred = 0;
    for (int c = 0; c < 100; c++) begin
      if (ped_ack) begin acks++; if (first_ack < 0) first_ack = c; end
      if (first_ack < 0 && ped_walk) walk_early++;
      if (first_ack >= 0 && !ped_walk) walk_lost++;
      if ({code_a, code_b} != 2'd0) nonred++;
      if (c == 21 || c == 50) ped_button = 1;
      if (c == 25 || c == 55) ped_button = 0;
      @(negedge clk);
    end
    n_tests++;
    if (first_ack != 28) begin n_fail++; $display("FAIL red_ack_cycle: got %0d, expected 28", first_ack); end
    n_tests++;
    if (acks != 1) begin n_fail++; $display("FAIL red_ack_count: got %0d, expected 1", acks); end
    n_tests++;
    if (walk_lost != 0 || walk_early != 0) begin
      n_fail++; $display("FAIL red_walk_level: got lost=%0d early=%0d, expected 0/0", walk_lost, walk_early);
    end
    n_tests++;
    if (nonred != 0) begin n_fail++; $display("FAIL red_nonred: got %0d, expected 0", nonred); end
    @(posedge clk); #3; rstb = 0; #1;
    n_tests++;
    if ({code_a, code_b, ped_walk} !== 3'b000) begin
      n_fail++; $display("FAIL async_walk_clear: got %b, expected 000", {code_a, code_b, ped_walk});
    end
    @(negedge clk); rstb = 1;
    $display("[TB] test_ped_red done");
  endtask

  task automatic test_ped_clear_cycle();
    int ack_cyc[$];
    int greens;
    car_sense = 1; ped_button = 0; do_reset();
    greens = 0;
    for (int c = 0; c < 80; c++) begin
      if (ped_ack) ack_cyc.push_back(c);
      if ({code_a, code_b} == 2'd2) greens++;
      if (c == 16 || c == 29) ped_button = 1;
      if (c == 19 || c == 32) ped_button = 0;
      @(negedge clk);
    end
    n_tests++;
    if (ack_cyc.size() != 2) begin
      n_fail++; $display("FAIL clear_ack_count: got %0d, expected 2", ack_cyc.size());
    end else begin
      n_tests++;
      if (ack_cyc[0] != 32 || ack_cyc[1] != 64) begin
        n_fail++; $display("FAIL clear_ack_cycles: got %0d,%0d, expected 32,64", ack_cyc[0], ack_cyc[1]);
      end
    end
    n_tests++;
    if (greens != 16) begin n_fail++; $display("FAIL clear_green_total: got %0d, expected 16", greens); end
    $display("[TB] test_ped_clear_cycle done");
  endtask

  task automatic test_reset_mid_green();
    int l;
    car_sense = 1; ped_button = 0; do_reset();
    for (int c = 0; c < 20; c++) begin
      if (c == 16) ped_button = 1;
      if (c == 18) ped_button = 0;
      @(negedge clk);
    end
    n_tests++;
    if ({code_a, code_b} !== 2'd2) begin
      n_fail++; $display("FAIL midgreen_pre: got %0d, expected 2", {code_a, code_b});
    end
    @(posedge clk); #3; rstb = 0; #1;
    n_tests++;
    if ({code_a, code_b, ped_walk} !== 3'b000) begin
      n_fail++; $display("FAIL midgreen_async: got %b, expected 000", {code_a, code_b, ped_walk});
    end
    @(negedge clk); rstb = 1;
    run_len(2'd0, 40, l); n_tests++;
    if (l != 12) begin n_fail++; $display("FAIL post_reset_red: got %0d, expected 12", l); end
    run_len(2'd1, 40, l);
    run_len(2'd2, 40, l); n_tests++;
    if (l != 20) begin n_fail++; $display("FAIL pending_lost_green: got %0d, expected 20", l); end
    $display("[TB] test_reset_mid_green done");
  endtask

  task automatic test_random();
    logic [4:0] exp_v, got_v;
    int rf;
    car_sense = 0; ped_button = 0; do_reset(); model_reset();
    rf = 0;
    for (int c = 0; c < 3000 && rf < 20; c++) begin
      exp_v = {m_code, m_walk, m_ack, m_tick};
      got_v = {code_a, code_b, ped_walk, ped_ack, phase_tick};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++; rf++;
        $display("FAIL random_cycle %0d: got %b, expected %b", c, got_v, exp_v);
      end
      if ($urandom_range(24) == 0) car_sense = ~car_sense;
      if ($urandom_range(39) == 0) ped_button = ~ped_button;
      @(posedge clk);
      model_step(car_sense, ped_button);
      @(negedge clk);
    end
    $display("[TB] test_random done");
  endtask

  initial begin
    test_reset();
    test_car_cycle();
    test_short_pulse();
    test_ped_green();
    test_ped_red();
    test_ped_clear_cycle();
    test_reset_mid_green();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
